// File: rtl/vga_scope_pkg.sv
// vga_scope_pkg: shared VGA geometry, cursor-select codes, cursor FSM states and the saturating step helper
package vga_scope_pkg;
    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;
    typedef enum logic [1:0] {SEL_X1 = 2'b00, SEL_X2 = 2'b01, SEL_Y1 = 2'b10, SEL_Y2 = 2'b11} sel_t;
    typedef enum logic [1:0] {IDLE = 2'b00, HOLD = 2'b01, REPEAT = 2'b10} state_t;
    // moves p by st in 12-bit arithmetic and clamps the result into [0, lim-1]
    function automatic logic [10:0] step_sat(input logic [10:0] p, input logic up, input logic [11:0] lim, input logic [11:0] st);
        logic [11:0] w_sum;
        w_sum = up ? {1'b0, p} + st : {1'b0, p} - st;
        if (!up && {1'b0, p} < st) return '0;
        if (w_sum > lim - 12'd1) return 11'(lim - 12'd1);
        return w_sum[10:0];
    endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchroniser plus stable-count debouncer for one active-low push-button
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_key_n        : raw button, asynchronous to i_clk
//   o_sync         : synchronised raw level
//   o_level        : debounced level (1 = released)
module key_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_sync,
    output logic o_level
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    assign o_sync = r_sync[1];
    // the synchroniser is left unreset so it tracks the button through reset
    always_ff @(posedge i_clk) r_sync <= {r_sync[0], i_key_n};
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            o_level <= 1'b1;
        end else if (r_sync[1] == o_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
            o_level <= ~o_level;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/scope_cursor_ctrl.sv
// scope_cursor_ctrl: debounced push-button control of four saturating scope cursors with press-and-hold repeat
//   clk50, reset_n           : 50 MHz clock, synchronous active-low reset
//   key_inc_n, key_dec_n     : raw active-low buttons
//   sw_axis, sw_cursor       : cursor select {axis, cursor}
//   sw_xen, sw_yen           : display enables, registered onto cursorX_EN / cursorY_EN
//   cursorX1..cursorY2       : cursor positions, clamped to the active area
module scope_cursor_ctrl
    import vga_scope_pkg::*;
#(
    parameter int STEP         = 1,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 2500000,
    parameter int X1_INIT      = 200,
    parameter int X2_INIT      = 600,
    parameter int Y1_INIT      = 150,
    parameter int Y2_INIT      = 450
) (
    input  logic        clk50,
    input  logic        reset_n,
    input  logic        key_inc_n,
    input  logic        key_dec_n,
    input  logic        sw_axis,
    input  logic        sw_cursor,
    input  logic        sw_xen,
    input  logic        sw_yen,
    output logic        cursorX_EN,
    output logic        cursorY_EN,
    output logic [10:0] cursorX1,
    output logic [10:0] cursorX2,
    output logic [10:0] cursorY1,
    output logic [10:0] cursorY2
);
    localparam int CMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(CMAX + 1);
    logic          w_inc_sync, w_dec_sync, w_inc_lvl, w_dec_lvl;
    logic          w_inc, w_dec, w_one, w_edge, w_step;
    logic [3:0]    r_sw1, r_sw2;
    sel_t          w_sel, r_sel;
    logic          r_inc_prev, r_dec_prev, r_lock, r_dir;
    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [10:0]   w_cur, w_new;
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc (
        .i_clk(clk50), .i_rst_n(reset_n), .i_key_n(key_inc_n), .o_sync(w_inc_sync), .o_level(w_inc_lvl)
    );
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dec (
        .i_clk(clk50), .i_rst_n(reset_n), .i_key_n(key_dec_n), .o_sync(w_dec_sync), .o_level(w_dec_lvl)
    );
    assign w_sel  = sel_t'(r_sw2[3:2]);
    assign w_inc  = ~w_inc_lvl;
    assign w_dec  = ~w_dec_lvl;
    assign w_one  = w_inc ^ w_dec;
    assign w_edge = (w_inc & ~r_inc_prev) | (w_dec & ~r_dec_prev);
    assign w_cur  = w_sel == SEL_X1 ? cursorX1 : w_sel == SEL_X2 ? cursorX2 : w_sel == SEL_Y1 ? cursorY1 : cursorY2;
    // inc moves right on X but up (towards 0) on Y
    assign w_new  = step_sat(w_cur, w_inc ^ w_sel[1], w_sel[1] ? 12'(V_ACTIVE) : 12'(H_ACTIVE), 12'(STEP));
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt + 1'b1;
        w_step  = 1'b0;
        // both keys, no key, a selection change or a swapped key all abandon the current press
        if (!w_one || w_sel != r_sel || (r_state != IDLE && w_inc != r_dir)) begin
            w_state = IDLE;
            w_cnt   = '0;
        end else if (r_state == IDLE) begin
            w_cnt = '0;
            if (w_edge && !r_lock) begin
                w_state = HOLD;
                w_step  = 1'b1;
            end
        end else if (r_state == HOLD && r_cnt == CW'(REPEAT_DELAY - 1)) begin
            w_state = REPEAT;
            w_cnt   = '0;
            w_step  = 1'b1;
        end else if (r_state == REPEAT && r_cnt == CW'(REPEAT_RATE - 1)) begin
            w_cnt  = '0;
            w_step = 1'b1;
        end
    end
    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            r_sw1      <= '0;
            r_sw2      <= '0;
            r_sel      <= SEL_X1;
            cursorX_EN <= 1'b0;
            cursorY_EN <= 1'b0;
            r_inc_prev <= 1'b0;
            r_dec_prev <= 1'b0;
            r_lock     <= 1'b1;
            r_dir      <= 1'b0;
            r_state    <= IDLE;
            r_cnt      <= '0;
            cursorX1   <= 11'(X1_INIT);
            cursorX2   <= 11'(X2_INIT);
            cursorY1   <= 11'(Y1_INIT);
            cursorY2   <= 11'(Y2_INIT);
        end else begin
            r_sw1      <= {sw_axis, sw_cursor, sw_yen, sw_xen};
            r_sw2      <= r_sw1;
            r_sel      <= w_sel;
            cursorX_EN <= r_sw2[0];
            cursorY_EN <= r_sw2[1];
            r_inc_prev <= w_inc;
            r_dec_prev <= w_dec;
            // a key held through reset is ignored until both keys are seen released
            r_lock     <= r_lock & ~(w_inc_sync & w_dec_sync);
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            if (w_step) r_dir <= w_inc;
            if (w_step && w_sel == SEL_X1) cursorX1 <= w_new;
            if (w_step && w_sel == SEL_X2) cursorX2 <= w_new;
            if (w_step && w_sel == SEL_Y1) cursorY1 <= w_new;
            if (w_step && w_sel == SEL_Y2) cursorY2 <= w_new;
        end
    end
endmodule

// File: tb/tb_scope_cursor_ctrl.sv
// tb_scope_cursor_ctrl: scoreboard bench with a press-schedule reference model for scope_cursor_ctrl
module tb_scope_cursor_ctrl;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 5;
    logic clk50 = 1'b0, reset_n = 1'b0, key_inc_n = 1'b1, key_dec_n = 1'b1;
    logic sw_axis = 1'b0, sw_cursor = 1'b0, sw_xen = 1'b0, sw_yen = 1'b0;
    logic cursorX_EN, cursorY_EN;
    logic [10:0] cursorX1, cursorX2, cursorY1, cursorY2;
    int errors = 0, checks = 0;
    logic [45:0] q[$];
    logic [45:0] m_e, m_a;
    always #10 clk50 = ~clk50;
    scope_cursor_ctrl #(.DEBOUNCE_CYC(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .clk50(clk50), .reset_n(reset_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
        .sw_axis(sw_axis), .sw_cursor(sw_cursor), .sw_xen(sw_xen), .sw_yen(sw_yen),
        .cursorX_EN(cursorX_EN), .cursorY_EN(cursorY_EN),
        .cursorX1(cursorX1), .cursorX2(cursorX2), .cursorY1(cursorY1), .cursorY2(cursorY2)
    );
    int pos[4];
    bit s1k[2], s2k[2], lvl_p[2], prev_p[2];
    int streak[2];
    bit lock, enx, eny, sess, sess_inc, active = 1'b0;
    bit [3:0] s1w, s2w;
    bit [1:0] selreg;
    int age;
    always @(posedge clk50) begin : model
        bit [1:0] sel;
        bit single, step, up;
        int lim;
        if (!reset_n) begin
            pos = '{200, 600, 150, 450};
            enx = 0; eny = 0; s1w = '0; s2w = '0; selreg = '0;
            lvl_p = '{0, 0}; prev_p = '{0, 0}; streak = '{0, 0};
            lock = 1; sess = 0; active = 1;
        end else begin
            sel = s2w[3:2];
            single = lvl_p[0] ^ lvl_p[1];
            step = 0;
            if (!single || sel != selreg || (sess && lvl_p[0] != sess_inc)) sess = 0;
            else if (sess) begin
                age++;
                step = (age >= RD) && ((age - RD) % RR == 0);
            end else if (!lock && ((lvl_p[0] && !prev_p[0]) || (lvl_p[1] && !prev_p[1]))) begin
                sess = 1; age = 0; sess_inc = lvl_p[0]; step = 1;
            end
            if (step) begin
                up = lvl_p[0] ^ sel[1];
                lim = sel[1] ? 600 : 800;
                if (up) pos[sel] = (pos[sel] + 1 > lim - 1) ? lim - 1 : pos[sel] + 1;
                else pos[sel] = (pos[sel] > 0) ? pos[sel] - 1 : 0;
            end
            prev_p = lvl_p;
            for (int k = 0; k < 2; k++) begin
                streak[k] = (s2k[k] != lvl_p[k]) ? streak[k] + 1 : 0;
                if (streak[k] == D) begin lvl_p[k] = s2k[k]; streak[k] = 0; end
            end
            if (!s2k[0] && !s2k[1]) lock = 0;
            enx = s2w[0]; eny = s2w[1]; selreg = sel;
            s2w = s1w;
            s1w = {sw_axis, sw_cursor, sw_yen, sw_xen};
        end
        s2k = s1k;
        s1k = '{!key_inc_n, !key_dec_n};
        if (active) q.push_back({enx, eny, 11'(pos[0]), 11'(pos[1]), 11'(pos[2]), 11'(pos[3])});
    end
    always @(posedge clk50) begin : monitor
        #1;
        if (q.size() > 0) begin
            m_e = q.pop_front();
            m_a = {cursorX_EN, cursorY_EN, cursorX1, cursorX2, cursorY1, cursorY2};
            checks++;
            if (m_a !== m_e) begin
                errors++;
                $display("FAIL snapshot t=%0t got en=%b%b x1=%0d x2=%0d y1=%0d y2=%0d want en=%b%b x1=%0d x2=%0d y1=%0d y2=%0d",
                         $time, m_a[45], m_a[44], m_a[43:33], m_a[32:22], m_a[21:11], m_a[10:0],
                         m_e[45], m_e[44], m_e[43:33], m_e[32:22], m_e[21:11], m_e[10:0]);
            end
        end
    end
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk50);
    endtask
    task automatic sel(input bit a, input bit c);
        sw_axis = a; sw_cursor = c;
        cyc(6);
    endtask
    task automatic hold(input bit inc, input bit dec, input int n);
        key_inc_n = !inc; key_dec_n = !dec;
        cyc(n);
        key_inc_n = 1'b1; key_dec_n = 1'b1;
        cyc(D + 8);
    endtask
    initial begin
        int n1, n2, m;
        cyc(4);
        reset_n = 1'b1;
        chk("rst_x1", cursorX1, 200); chk("rst_x2", cursorX2, 600);
        chk("rst_y1", cursorY1, 150); chk("rst_y2", cursorY2, 450);
        chk("rst_xen", cursorX_EN, 0); chk("rst_yen", cursorY_EN, 0);
        sw_xen = 1'b1;
        cyc(2);
        chk("xen_lat2", cursorX_EN, 0);
        cyc(1);
        chk("xen_lat3", cursorX_EN, 1);
        sel(0, 0);
        repeat (2) begin
            key_inc_n = 1'b0; cyc(2);
            key_inc_n = 1'b1; cyc(2);
        end
        cyc(4);
        chk("glitch_x1", cursorX1, 200);
        hold(1, 0, 10);
        chk("single_x1", cursorX1, 201);
        sel(1, 1);
        hold(1, 0, 40);
        chk("repeat_y2", cursorY2, 445);
        sel(0, 1);
        hold(1, 0, 1200);
        chk("sat_x2", cursorX2, 799);
        sel(1, 0);
        hold(1, 0, 900);
        chk("sat_y1", cursorY1, 0);
        sel(0, 0);
        key_inc_n = 1'b0; key_dec_n = 1'b0;
        cyc(30);
        key_dec_n = 1'b1;
        cyc(30);
        key_inc_n = 1'b1;
        cyc(D + 8);
        chk("both_x1", cursorX1, 201);
        hold(1, 0, 10);
        chk("fresh_x1", cursorX1, 202);
        sel(0, 1);
        key_dec_n = 1'b0;
        cyc(60);
        sw_cursor = 1'b0;
        cyc(40);
        key_dec_n = 1'b1;
        cyc(D + 8);
        chk("selchg_x1", cursorX1, 202);
        hold(0, 1, 10);
        chk("repress_x1", cursorX1, 201);
        key_inc_n = 1'b0;
        cyc(40);
        reset_n = 1'b0;
        cyc(4);
        reset_n = 1'b1;
        cyc(40);
        key_inc_n = 1'b1;
        cyc(D + 8);
        chk("midrst_x1", cursorX1, 200); chk("midrst_x2", cursorX2, 600);
        chk("midrst_y1", cursorY1, 150); chk("midrst_y2", cursorY2, 450);
        hold(1, 0, 10);
        chk("postrst_x1", cursorX1, 201);
        repeat (40) begin
            sw_xen = 1'($urandom_range(0, 1));
            sw_yen = 1'($urandom_range(0, 1));
            sel(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                key_inc_n = 1'b0; cyc($urandom_range(1, 3));
                key_inc_n = 1'b1; cyc($urandom_range(1, 3));
            end
            m = $urandom_range(0, 3);
            n1 = $urandom_range(1, 60);
            n2 = $urandom_range(0, 30);
            key_inc_n = !m[0]; key_dec_n = !m[1];
            cyc(n1);
            if ($urandom_range(0, 3) == 0) sw_cursor = ~sw_cursor;
            if ($urandom_range(0, 5) == 0) key_dec_n = ~key_dec_n;
            cyc(n2);
            key_inc_n = 1'b1; key_dec_n = 1'b1;
            cyc(D + 8);
            if ($urandom_range(0, 7) == 0) begin
                reset_n = 1'b0; cyc(3); reset_n = 1'b1; cyc(2);
            end
        end
        cyc(5);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
